// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data_mem block.
//   ACC_*    : load/store access codes (B, H, W, BU, HU)
//   pipe_t   : response pipeline entry (valid, we, access, off, err)
//   state_t  : control FSM states (CLEAR, RUN)
package data_mem_pkg;

    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [2:0] access;
        logic [1:0] off;
        logic       err;
    } pipe_t;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_lane.sv
// data_mem_lane: byte-lane helper shared by the store and load paths.
//   i_access  : access code
//   i_off     : byte offset within the word (addr[1:0])
//   i_wdata   : right-aligned store data
//   i_rword   : raw word read from the array
//   o_be_c    : store byte enables
//   o_wdata_c : store data replicated into the addressed lane(s)
//   o_rdata_c : load result extracted and sign/zero extended
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [2:0]  i_access,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be_c,
    output logic [31:0] o_wdata_c,
    output logic [31:0] o_rdata_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: replication places data in every lane, enables pick the real ones
    always_comb begin
        o_be_c    = 4'b0000;
        o_wdata_c = i_wdata;
        case (i_access)
            ACC_B: begin
                o_be_c    = 4'(4'b0001 << i_off);
                o_wdata_c = {4{i_wdata[7:0]}};
            end
            ACC_H: begin
                o_be_c    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata_c = {2{i_wdata[15:0]}};
            end
            ACC_W: begin
                o_be_c    = 4'b1111;
                o_wdata_c = i_wdata;
            end
            default: o_be_c = 4'b0000;
        endcase
    end

    // Load side: lane select then extend
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
        case (i_access)
            ACC_B:   o_rdata_c = {{24{w_byte[7]}}, w_byte};
            ACC_BU:  o_rdata_c = {24'd0, w_byte};
            ACC_H:   o_rdata_c = {{16{w_half[15]}}, w_half};
            ACC_HU:  o_rdata_c = {16'd0, w_half};
            ACC_W:   o_rdata_c = i_rword;
            default: o_rdata_c = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// data_mem: byte/half/word data memory with valid/ready requests,
// configurable read latency and error reporting.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_req_valid/o_req_ready : request handshake
//   i_req_we, i_req_access  : store flag, access code
//   i_req_addr, i_req_wdata : byte address, right-aligned store data
//   o_resp_valid            : one-cycle response strobe per accepted request
//   o_resp_rdata            : extended load data (0 for stores/errors)
//   o_resp_err              : misaligned, out-of-range or illegal request
// Macro DATA_MEM_CLEAR_EN: zero the array word by word after every reset.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_access,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 32'(1) << IDX_W;

    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic        w_ready_next;

    logic        w_accept;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_oor;
    logic        w_err;
    logic        w_st_we;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic [31:0] w_rd_word;
    logic [31:0] w_ld_data;
    logic [31:0] w_unused_st_rdata;
    logic [3:0]  w_unused_ld_be;
    logic [31:0] w_unused_ld_wdata;

    pipe_t       w_entry;
    pipe_t       w_head;
    logic [31:0] w_head_word;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    assign o_req_ready  = r_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
`ifdef DATA_MEM_CLEAR_EN
            r_state <= S_CLEAR;
            r_ready <= 1'b0;
`else
            r_state <= S_RUN;
            r_ready <= 1'b1;
`endif
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
        end
    end

`ifdef DATA_MEM_CLEAR_EN
    logic [IDX_W-1:0] r_clr_idx;
    logic             w_clr_we;

    // Next state: walk the clear index to the last word, then run
    always_comb begin
        w_state_next = r_state;
        w_clr_we     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
        w_ready_next = (w_state_next == S_RUN);
    end

    // Clear index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clr_idx <= '0;
        end else if (w_clr_we) begin
            r_clr_idx <= r_clr_idx + IDX_W'(1);
        end
    end
`else
    // Next state: no clear phase
    always_comb begin
        w_state_next = S_RUN;
        w_ready_next = 1'b1;
    end
`endif

    assign w_accept = i_req_valid && r_ready && !i_rst;
    assign w_idx    = i_req_addr[ADDR_W-1:2];

    // Request error classification
    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        case (i_req_access)
            ACC_B, ACC_BU: w_misalign = 1'b0;
            ACC_H, ACC_HU: w_misalign = i_req_addr[0];
            ACC_W:         w_misalign = |i_req_addr[1:0];
            default:       w_illegal  = 1'b1;
        endcase
        if (i_req_we && (i_req_access == ACC_BU || i_req_access == ACC_HU)) begin
            w_illegal = 1'b1;
        end
    end

    assign w_oor   = |i_req_addr[31:ADDR_W];
    assign w_err   = w_misalign || w_illegal || w_oor;
    assign w_st_we = w_accept && i_req_we && !w_err;

    data_mem_lane u_st_lane (
        .i_access  (i_req_access),
        .i_off     (i_req_addr[1:0]),
        .i_wdata   (i_req_wdata),
        .i_rword   (32'd0),
        .o_be_c    (w_st_be),
        .o_wdata_c (w_st_data),
        .o_rdata_c (w_unused_st_rdata)
    );

    // Array write: clear sweep or byte-enabled store
    always_ff @(posedge i_clk) begin
`ifdef DATA_MEM_CLEAR_EN
        if (w_clr_we && !i_rst) begin
            r_mem[r_clr_idx] <= 32'd0;
        end else
`endif
        if (w_st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_st_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
                end
            end
        end
    end

    // Read at accept sees any store from the previous edge
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_entry        = '0;
        w_entry.valid  = w_accept;
        w_entry.we     = i_req_we;
        w_entry.access = i_req_access;
        w_entry.off    = i_req_addr[1:0];
        w_entry.err    = w_err;
    end

    // READ_LAT-1 delay stages ahead of the response register
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign w_head      = w_entry;
            assign w_head_word = w_rd_word;
        end else begin : g_pipe
            pipe_t       r_pipe [READ_LAT-1];
            logic [31:0] r_word [READ_LAT-1];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < int'(READ_LAT) - 1; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_entry;
                    for (int i = 1; i < int'(READ_LAT) - 1; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                r_word[0] <= w_rd_word;
                for (int i = 1; i < int'(READ_LAT) - 1; i++) begin
                    r_word[i] <= r_word[i-1];
                end
            end

            assign w_head      = r_pipe[READ_LAT-2];
            assign w_head_word = r_word[READ_LAT-2];
        end
    endgenerate

    data_mem_lane u_ld_lane (
        .i_access  (w_head.access),
        .i_off     (w_head.off),
        .i_wdata   (32'd0),
        .i_rword   (w_head_word),
        .o_be_c    (w_unused_ld_be),
        .o_wdata_c (w_unused_ld_wdata),
        .o_rdata_c (w_ld_data)
    );

    // Response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_head.valid;
            r_resp_err   <= w_head.valid && w_head.err;
            r_resp_rdata <= (w_head.valid && !w_head.we && !w_head.err) ? w_ld_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem.
// Two instances: READ_LAT=1 (functional/error tests) and READ_LAT=3
// (latency, ordering, mid-flight reset). Honours DATA_MEM_CLEAR_EN.
module tb_data_mem;
    import data_mem_pkg::*;

`ifdef DATA_MEM_CLEAR_EN
    localparam int   EXP_CLR  = 1024;
    localparam logic EXP_RDY0 = 1'b0;
`else
    localparam int   EXP_CLR  = 0;
    localparam logic EXP_RDY0 = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst1, v1, we1, rdy1, rv1, re1;
    logic [2:0]  acc1;
    logic [31:0] addr1, wd1, rd1;
    logic        rst3, v3, we3, rdy3, rv3, re3;
    logic [2:0]  acc3;
    logic [31:0] addr3, wd3, rd3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem #(.ADDR_W(12), .READ_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_req_valid(v1), .o_req_ready(rdy1),
        .i_req_we(we1), .i_req_access(acc1), .i_req_addr(addr1), .i_req_wdata(wd1),
        .o_resp_valid(rv1), .o_resp_rdata(rd1), .o_resp_err(re1)
    );

    data_mem #(.ADDR_W(12), .READ_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst3), .i_req_valid(v3), .o_req_ready(rdy3),
        .i_req_we(we3), .i_req_access(acc3), .i_req_addr(addr3), .i_req_wdata(wd3),
        .o_resp_valid(rv3), .o_resp_rdata(rd3), .o_resp_err(re3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One request on the READ_LAT=1 instance; response checked right after accept
    task automatic req1(input string tag, input logic we, input logic [2:0] acc,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic eerr, input logic [31:0] erd);
        @(negedge clk);
        v1 = 1'b1; we1 = we; acc1 = acc; addr1 = addr; wd1 = wd;
        chk({tag, ".rdy"}, 32'(rdy1), 32'd1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk({tag, ".v"}, 32'(rv1), 32'd1);
        chk({tag, ".e"}, 32'(re1), 32'(eerr));
        chk({tag, ".d"}, rd1, erd);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst1 = 1'b0; v1 = 1'b0; we1 = 1'b0; acc1 = 3'd0; addr1 = 32'd0; wd1 = 32'd0;
        rst3 = 1'b0; v3 = 1'b0; we3 = 1'b0; acc3 = 3'd0; addr3 = 32'd0; wd3 = 32'd0;

        // Reset both instances for one edge
        @(negedge clk);
        rst1 = 1'b1; rst3 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.v", 32'(rv1), 32'd0);
        chk("rst.e", 32'(re1), 32'd0);
        chk("rst.d", rd1, 32'd0);
        chk("rst.rdy", 32'(rdy1), 32'(EXP_RDY0));
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        n = 0;
        while (rdy1 == 1'b0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("clr_cycles", 32'(n), 32'(EXP_CLR));

`ifdef DATA_MEM_CLEAR_EN
        req1("clr_lw", 1'b0, ACC_W, 32'h3FC, 32'd0, 1'b0, 32'd0);
`endif

        req1("sw0",   1'b1, ACC_W,  32'd0, 32'h00112233, 1'b0, 32'd0);
        req1("sw4",   1'b1, ACC_W,  32'd4, 32'hAABBCCDD, 1'b0, 32'd0);
        req1("lb7",   1'b0, ACC_B,  32'd7, 32'd0, 1'b0, 32'hFFFFFFAA);
        req1("lbu7",  1'b0, ACC_BU, 32'd7, 32'd0, 1'b0, 32'h000000AA);
        req1("lh6",   1'b0, ACC_H,  32'd6, 32'd0, 1'b0, 32'hFFFFAABB);
        req1("lhu2",  1'b0, ACC_HU, 32'd2, 32'd0, 1'b0, 32'h00000011);
        req1("lw4",   1'b0, ACC_W,  32'd4, 32'd0, 1'b0, 32'hAABBCCDD);

        req1("sw0b",  1'b1, ACC_W,  32'd0, 32'h01234567, 1'b0, 32'd0);
        req1("sh2",   1'b1, ACC_H,  32'd2, 32'h0000AABB, 1'b0, 32'd0);
        req1("sb1",   1'b1, ACC_B,  32'd1, 32'h00000077, 1'b0, 32'd0);
        req1("lw0",   1'b0, ACC_W,  32'd0, 32'd0, 1'b0, 32'hAABB7767);

        req1("e_lh3",  1'b0, ACC_H,  32'd3,      32'd0,        1'b1, 32'd0);
        req1("e_sw6",  1'b1, ACC_W,  32'd6,      32'h55555555, 1'b1, 32'd0);
        req1("e_011",  1'b0, 3'b011, 32'd0,      32'd0,        1'b1, 32'd0);
        req1("e_oor",  1'b0, ACC_W,  32'h1000,   32'd0,        1'b1, 32'd0);
        req1("e_sbu",  1'b1, ACC_BU, 32'd4,      32'h00000099, 1'b1, 32'd0);
        req1("e_oorw", 1'b1, ACC_W,  32'h1004,   32'h12345678, 1'b1, 32'd0);
        req1("lw4b",   1'b0, ACC_W,  32'd4,      32'd0,        1'b0, 32'hAABBCCDD);

        // Store followed immediately by load of the same word
        req1("haz_sw", 1'b1, ACC_W,  32'hFFC,    32'hCAFEF00D, 1'b0, 32'd0);
        req1("haz_lw", 1'b0, ACC_W,  32'hFFC,    32'd0,        1'b0, 32'hCAFEF00D);
        req1("haz_lb", 1'b0, ACC_B,  32'hFFD,    32'd0,        1'b0, 32'hFFFFFFF0);
        @(posedge clk);
        #1;
        chk("idle.v", 32'(rv1), 32'd0);

        // READ_LAT=3: store then load back-to-back
        @(negedge clk);
        n = 0;
        while (rdy3 == 1'b0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("rdy3", 32'(rdy3), 32'd1);
        v3 = 1'b1; we3 = 1'b1; acc3 = ACC_W; addr3 = 32'd8; wd3 = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        chk("l3.e0", 32'(rv3), 32'd0);
        @(posedge clk);
        #1;
        v3 = 1'b0;
        chk("l3.e1", 32'(rv3), 32'd0);
        @(posedge clk);
        #1;
        chk("l3.v1", 32'(rv3), 32'd1);
        chk("l3.e_1", 32'(re3), 32'd0);
        chk("l3.d1", rd3, 32'd0);
        @(posedge clk);
        #1;
        chk("l3.v2", 32'(rv3), 32'd1);
        chk("l3.d2", rd3, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("l3.v3", 32'(rv3), 32'd0);

        // Mid-flight reset drops both loads
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b0; acc3 = ACC_W; addr3 = 32'd8;
        @(posedge clk);
        #1;
        addr3 = 32'd0;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        chk("mr.rdy", 32'(rdy3), 32'(EXP_RDY0));
        n = (rv3 === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rv3 === 1'b1) n++;
        end
        chk("mr.novalid", 32'(n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
Parametrised successor to the single-cycle byte/half/word RAM. It keeps the LB/LH/LW/LBU/LHU encoding. New capabilities:
- valid/ready request handshake
- configurable read latency
- misalignment and range error reporting
- hardware clear sequence after reset

It is the data memory behind the core's load/store unit; exactly one request is accepted per cycle.

Parameters:
ADDR_W, 12, byte-address width; capacity 2^ADDR_W bytes, organised as 2^(ADDR_W-2) 32-bit words; legal range 3..20.
READ_LAT, 1, cycles from request accept to response; legal range 1..4.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_access  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; all other codes illegal
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (low byte/half used for B/H)
resp_valid  output  1  one-cycle response strobe, one per accepted request (loads and stores)
resp_rdata  output  32  load result, sign/zero extended; 0 for stores and errors
resp_err  output  1  accepted request was misaligned, out of range or illegal

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset (rst high at an edge) forces:
  - resp_valid=0, resp_rdata=0, resp_err=0
  - all pipeline valid bits cleared; in-flight requests are dropped with no response
  - FSM to CLEAR (macro on) or RUN (macro off); clear index to 0
  - this also applies when reset is asserted mid-operation or mid-clear.
- FSM states: CLEAR, RUN. In CLEAR, req_ready=0 and the block writes zero to one word per cycle, index 0 upward. After the last word (index 2^(ADDR_W-2)-1) it moves to RUN. In RUN, req_ready=1 permanently.
- Accept condition: req_valid && req_ready at a rising edge. Requests presented while req_ready=0 are ignored, not queued.
- Error checks, evaluated at accept:
  - misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0
  - out of range: any of addr[31:ADDR_W] nonzero
  - illegal code: 011, 110, 111; also store with 100/101
- An errored request performs no array write. Its response carries resp_err=1 and resp_rdata=0.
- Store: the array write occurs at the accept edge using byte enables derived from access and addr[1:0]:
  - B writes 1 lane (lane = addr[1:0])
  - H writes lanes {addr[1],0} and {addr[1],1}
  - W writes all 4 lanes
  - Data is shifted into the addressed lane(s).
- Load: the array is read at the accept edge. The lane is extracted using the offset carried in the pipeline. B/H results are sign-extended; BU/HU results are zero-extended.
- Latency: for a request accepted at edge E, resp_valid=1 for exactly the one cycle following edge E+READ_LAT-1, together with resp_rdata and resp_err. Back-to-back requests give back-to-back responses in order.
- Hazard rule: a store accepted at edge E followed by a load of the same address accepted at E+1 returns the new data, at any READ_LAT.
- The pipeline stages carry valid, we, access, addr[1:0] and err. Responses have no backpressure.
- Address bits [ADDR_W-1:2] select the word. Index arithmetic is unsigned; there is no wrap-around into a legal range.

Optional Feature:
DATA_MEM_CLEAR_EN
- Defined: CLEAR state present. After every reset, req_ready stays low for 2^(ADDR_W-2) cycles while memory is zeroed.
- Undefined: no clear logic. FSM goes straight to RUN, so req_ready=1 on the first cycle after reset release. Array contents persist across reset; only control and output registers reset.

Decomposition:
- Package data_mem_pkg holds:
  - access-code constants ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU
  - pipeline-entry struct (valid, we, access, off, err)
  - FSM state enum
- One sub-module, data_mem_lane: combinational store byte-enable/shift generation and load extract/extend. It is shared logic, instantiated once on each side.

Test Plan:
- Clear, macro on, ADDR_W=12: assert rst for 1 cycle, then release. req_ready must stay 0 for exactly 1024 cycles. An LW of addr 0x3FC afterwards returns 0.
- Word/half/byte stores, READ_LAT=1:
  - SW 0x00112233 at 0, then SW 0xAABBCCDD at 4.
  - LB 7 -> 0xFFFFFFAA; LBU 7 -> 0x000000AA; LH 6 -> 0xFFFFAABB; LHU 2 -> 0x00000011; LW 4 -> 0xAABBCCDD.
  - Each response arrives one cycle after accept, with resp_err=0.
- Partial overwrite: after SW 0x01234567 at 0, SH 0xAABB at 2 and SB 0x77 at 1, LW 0 -> 0xAABB7767.
- Errors:
  - LH 3, SW 6, access 011 at 0, and LW 0x1000 (ADDR_W=12) each give resp_err=1, resp_rdata=0.
  - A following LW 4 shows the array is unchanged.
- Latency/ordering, READ_LAT=3: SW 0xDEADBEEF at 8, then LW 8 on consecutive cycles. Two resp_valid pulses arrive on consecutive cycles 3 cycles after each accept; the second carries 0xDEADBEEF.
- Reset mid-flight, READ_LAT=3: issue 2 loads, assert rst the next cycle. No resp_valid must appear, and req_ready follows the post-reset rule for the selected macro setting.
